// File: rtl/lcu_opq_pkg.sv
// lcu_opq_pkg: shared types and bit positions for the lcu micro-operation queue.
package lcu_opq_pkg;
    localparam int Y_W = 23;
    localparam int Y1_B = 0, Y2_B = 1, Y3_B = 2, Y4_B = 3, Y5_B = 4, Y6_B = 5;
    localparam int Y7_B = 6, Y8_B = 7, Y9_B = 8, Y10_B = 9, Y11_B = 10, Y12_B = 11;
    localparam int Y13_B = 12, Y14_B = 13, Y15_B = 14, Y16_B = 15, Y17_B = 16;
    localparam int Y18_B = 17, Y19_B = 18, Y21_B = 19, Y22_B = 20, Y23_B = 21, Y24_B = 22;
    typedef logic [Y_W-1:0] lcu_op_t;
    localparam lcu_op_t DONE_MASK = lcu_op_t'((1 << Y17_B) | (1 << Y18_B) | (1 << Y19_B));
    function automatic logic is_last(input lcu_op_t w);
        return (w & DONE_MASK) == DONE_MASK;
    endfunction
endpackage

// File: rtl/lcu_opq_fifo.sv
// lcu_opq_fifo: power-of-two FIFO with occupancy; a push into a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module lcu_opq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 23,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_din,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [LW-1:0] r_level;
    logic          w_wr_en, w_rd_en;

    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd];
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_rd_en) r_rd <= r_rd + 1'b1;
            r_level <= r_level + LW'(w_wr_en) - LW'(w_rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/lcu_op_queue.sv
// lcu_op_queue: queues non-zero lcu controller words and issues them over valid/ready.
// Optional LCU_OPQ_DEDUP_EN suppresses repeats of the previous edge's word.
module lcu_op_queue
    import lcu_opq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Y_W-1:0]         y_in,
    input  logic                   ovf_clr,
    input  logic                   op_ready,
    output logic                   op_valid,
    output logic [Y_W-1:0]         op_word,
    output logic                   op_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic [CNT_W-1:0]       op_count,
    output logic                   seq_done
);
    lcu_op_t          w_head;
    logic             w_push, w_pop, w_full, w_empty;
    logic             r_ovf, r_seq_done;
    logic [CNT_W-1:0] r_count;

`ifdef LCU_OPQ_DEDUP_EN
    lcu_op_t r_prev_y;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_prev_y <= '0;
        else      r_prev_y <= y_in;
    end
    assign w_push = (y_in != '0) && (y_in != r_prev_y);
`else
    assign w_push = y_in != '0;
`endif

    lcu_opq_fifo #(.DEPTH(DEPTH), .W(Y_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (y_in),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign op_valid = ~w_empty;
    assign op_word  = w_empty ? '0 : w_head;
    assign op_last  = ~w_empty & is_last(w_head);
    assign w_pop    = op_valid & op_ready;
    assign ovf      = r_ovf;
    assign op_count = r_count;
    assign seq_done = r_seq_done;

    // A drop (push while full, no pop) wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf      <= 1'b0;
            r_count    <= '0;
            r_seq_done <= 1'b0;
        end else begin
            if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
            else if (ovf_clr)             r_ovf <= 1'b0;
            if (w_pop && !(&r_count)) r_count <= r_count + 1'b1;
            r_seq_done <= w_pop & op_last;
        end
    end
endmodule

// File: tb/tb_lcu_op_queue.sv
// tb_lcu_op_queue: directed and random stimulus checked against a queue-based model.
module tb_lcu_op_queue;
    import lcu_opq_pkg::*;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0, rst = 1'b0, ovf_clr = 1'b0, op_ready = 1'b0;
    lcu_op_t                y_in = '0;
    logic                   op_valid, op_last, ovf, seq_done;
    lcu_op_t                op_word;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       op_count;

    lcu_op_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .ovf_clr(ovf_clr), .op_ready(op_ready),
        .op_valid(op_valid), .op_word(op_word), .op_last(op_last), .level(level),
        .ovf(ovf), .op_count(op_count), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int      n_chk = 0, n_pass = 0;
    lcu_op_t q[$];
    logic    m_ovf = 1'b0, m_seq = 1'b0;
    int      m_cnt = 0;
    lcu_op_t m_prev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_seq = 1'b0; m_cnt = 0; m_prev = '0;
    endtask

    task automatic check_all();
        lcu_op_t head;
        head = q.size() ? q[0] : '0;
        chk("op_valid", 32'(op_valid), 32'(q.size() != 0));
        chk("op_word",  32'(op_word), 32'(head));
        chk("op_last",  32'(op_last), 32'((head & DONE_MASK) == DONE_MASK && q.size() != 0));
        chk("level",    32'(level), 32'(q.size()));
        chk("ovf",      32'(ovf), 32'(m_ovf));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("seq_done", 32'(seq_done), 32'(m_seq));
    endtask

    // Drive at a negedge, advance the model across the next posedge, check at the following negedge.
    task automatic step(input lcu_op_t y, input logic rdy, input logic clr);
        logic pop, push, last, full;
        y_in = y; op_ready = rdy; ovf_clr = clr;
        pop  = rdy && q.size() != 0;
        last = pop && (q[0] & DONE_MASK) == DONE_MASK;
        full = q.size() == DEPTH;
        push = y != 0;
`ifdef LCU_OPQ_DEDUP_EN
        push = push && y != m_prev;
`endif
        if (pop) void'(q.pop_front());
        if (push && full && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (push && !(full && !pop)) q.push_back(y);
        if (pop && m_cnt != (1 << CNT_W) - 1) m_cnt++;
        m_seq = last;
        m_prev = y;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        lcu_op_t y;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        // basic issue
        step(23'h000006, 1'b1, 1'b0);
        chk("basic_word", 32'(op_word), 32'h6);
        step('0, 1'b1, 1'b0);
        chk("basic_cnt", 32'(op_count), 32'd1);
        chk("basic_lvl", 32'(level), 32'd0);
        // overflow and clear
        for (int i = 1; i <= 5; i++) step(lcu_op_t'(i), 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_lvl", 32'(level), 32'd4);
        step('0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(ovf), 32'd0);
        // full with simultaneous push and pop, then drain in order
        step(23'h000055, 1'b1, 1'b0);
        chk("full_sim_lvl", 32'(level), 32'd4);
        chk("full_sim_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
        // sequence terminator
        step(23'h070000, 1'b0, 1'b0);
        chk("term_last", 32'(op_last), 32'd1);
        step('0, 1'b1, 1'b0);
        chk("term_done", 32'(seq_done), 32'd1);
        step('0, 1'b1, 1'b0);
        chk("term_done_end", 32'(seq_done), 32'd0);
        // repeated word from a controller self-loop
        for (int i = 0; i < 3; i++) step(23'h000200, 1'b0, 1'b0);
`ifdef LCU_OPQ_DEDUP_EN
        chk("dedup_lvl", 32'(level), 32'd1);
`else
        chk("dedup_lvl", 32'(level), 32'd3);
`endif
        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0);
        // asynchronous reset mid-operation
        for (int i = 1; i <= 3; i++) step(lcu_op_t'(i), 1'b0, 1'b0);
        chk("pre_rst_lvl", 32'(level), 32'd3);
        y_in = 23'h000007; op_ready = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        step(23'h000006, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        chk("post_rst_cnt", 32'(op_count), 32'd1);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(9))
                0, 1, 2, 3: y = '0;
                4, 5:       y = y_in;
                6:          y = 23'h070000;
                default:    y = lcu_op_t'($urandom);
            endcase
            step(y, $urandom_range(9) < 6, $urandom_range(9) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
